// File: rtl/dab_gate_generator.sv
// Gate pattern generator for a dual-active-bridge: 1024-step period, SPS/TPS leg timing, per-leg dead-time.
// Optional shoot-through checker enabled by defining DAB_GATE_SHOOTTHRU_EN.
module dab_gate_generator #(
  parameter int DIV      = 1,
  parameter int DEADTIME = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       upd,
  input  logic [8:0] tau1,
  input  logic [8:0] tau2,
  input  logic [8:0] phi,
  input  logic [1:0] modo,
  output logic [3:0] g1,
  output logic [3:0] g2,
  output logic       sync,
  output logic       fault
);

  localparam logic [1:0] MODE_SPS = 2'b01;
  localparam logic [1:0] MODE_TPS = 2'b10;
  localparam logic [1:0] LEG_OFF  = 2'b00;
  localparam logic [1:0] LEG_HI   = 2'b01;
  localparam logic [1:0] LEG_LO   = 2'b10;
  localparam int         PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0] DT       = 8'(DEADTIME);

  logic [PW-1:0] presc_r;
  logic [9:0]    step_r;
  logic [8:0]    sh_tau1_r, sh_tau2_r, sh_phi_r;
  logic [1:0]    sh_modo_r;
  logic [8:0]    act_tau1_r, act_tau2_r, act_phi_r;
  logic [1:0]    act_modo_r;
  logic [3:0]    hi_r, lo_r;
  logic [1:0]    tgt_r [4];
  logic [7:0]    dt_cnt_r [4];
  logic          sync_r;
  logic          fault_r;

  logic          tick_s, wrap_s, run_s;
  logic [9:0]    t1_s, t2_s, s2_s;
  logic [3:0]    cmd_s;
  logic [1:0]    req_s [4];

  // Leg B is high once the step, advanced by half a period minus the pulse width, reaches the second half.
  function automatic logic leg_b_cmd(input logic [9:0] s, input logic [9:0] t);
    logic [9:0] d;
    d = s + 10'd512 - t;
    return d[9];
  endfunction

  // Step timing, effective pulse widths and per-leg requested state.
  always_comb begin
    tick_s = enable && (presc_r == PRESC_MAX);
    wrap_s = tick_s && (step_r == 10'd1023);
    run_s  = enable && ((act_modo_r == MODE_SPS) || (act_modo_r == MODE_TPS));
    if (act_modo_r == MODE_SPS) begin
      t1_s = 10'd512;
      t2_s = 10'd512;
    end else begin
      t1_s = {1'b0, act_tau1_r};
      t2_s = {1'b0, act_tau2_r};
    end
    s2_s     = step_r - {act_phi_r[8], act_phi_r};
    cmd_s[0] = ~step_r[9];
    cmd_s[1] = leg_b_cmd(step_r, t1_s);
    cmd_s[2] = ~s2_s[9];
    cmd_s[3] = leg_b_cmd(s2_s, t2_s);
    for (int i = 0; i < 4; i++) begin
      req_s[i] = LEG_OFF;
      if (!run_s) begin
        req_s[i] = LEG_OFF;
      end else if (cmd_s[i]) begin
        req_s[i] = LEG_HI;
      end else begin
        req_s[i] = LEG_LO;
      end
    end
  end

  // Prescaler and period step counter; both held at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      step_r  <= 10'd0;
      sync_r  <= 1'b0;
    end else begin
      sync_r <= enable && (step_r == 10'd0) && (presc_r == '0);
      if (!enable) begin
        presc_r <= '0;
        step_r  <= 10'd0;
      end else if (tick_s) begin
        presc_r <= '0;
        step_r  <= step_r + 10'd1;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Shadow capture on upd; active set only changes at the period wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tau1_r  <= 9'd0;
      sh_tau2_r  <= 9'd0;
      sh_phi_r   <= 9'd0;
      sh_modo_r  <= 2'b00;
      act_tau1_r <= 9'd0;
      act_tau2_r <= 9'd0;
      act_phi_r  <= 9'd0;
      act_modo_r <= 2'b00;
    end else begin
      if (upd) begin
        sh_tau1_r <= tau1;
        sh_tau2_r <= tau2;
        sh_phi_r  <= phi;
        sh_modo_r <= modo;
      end
      if (wrap_s) begin
        act_tau1_r <= upd ? tau1 : sh_tau1_r;
        act_tau2_r <= upd ? tau2 : sh_tau2_r;
        act_phi_r  <= upd ? phi  : sh_phi_r;
        act_modo_r <= upd ? modo : sh_modo_r;
      end
    end
  end

  // Per-leg dead-time: any change of requested state drops both switches, then the new one rises DT clks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 4'b0000;
      lo_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tgt_r[i]    <= LEG_OFF;
        dt_cnt_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fault_r) begin
          hi_r[i]     <= 1'b0;
          lo_r[i]     <= 1'b0;
          tgt_r[i]    <= LEG_OFF;
          dt_cnt_r[i] <= 8'd0;
        end else if (req_s[i] != tgt_r[i]) begin
          tgt_r[i]    <= req_s[i];
          dt_cnt_r[i] <= DT;
          hi_r[i]     <= (DT == 8'd0) && (req_s[i] == LEG_HI);
          lo_r[i]     <= (DT == 8'd0) && (req_s[i] == LEG_LO);
        end else if (dt_cnt_r[i] != 8'd0) begin
          dt_cnt_r[i] <= dt_cnt_r[i] - 8'd1;
          if (dt_cnt_r[i] == 8'd1) begin
            hi_r[i] <= (tgt_r[i] == LEG_HI);
            lo_r[i] <= (tgt_r[i] == LEG_LO);
          end
        end
      end
    end
  end

`ifdef DAB_GATE_SHOOTTHRU_EN
  // Sticky shoot-through detection on the registered switch pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r | (|(hi_r & lo_r));
    end
  end
`else
  // Checker absent: fault permanently cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= 1'b0;
    end
  end
`endif

  assign g1    = {hi_r[0], lo_r[0], hi_r[1], lo_r[1]};
  assign g2    = {hi_r[2], lo_r[2], hi_r[3], lo_r[3]};
  assign sync  = sync_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_dab_gate_generator.sv
// Directed bench for dab_gate_generator with DIV=1, DEADTIME=4; expected gate words are hand-derived.
module tb_dab_gate_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       upd;
  logic [8:0] tau1, tau2, phi;
  logic [1:0] modo;
  logic [3:0] g1, g2;
  logic       sync, fault;

  int checks = 0;
  int errors = 0;
  int pos    = -1;
  logic ov;

  dab_gate_generator #(.DIV(1), .DEADTIME(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .upd(upd),
    .tau1(tau1), .tau2(tau2), .phi(phi), .modo(modo),
    .g1(g1), .g2(g2), .sync(sync), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge after rising edge number k (counted from the last enable rise).
  task automatic goto(input int k);
    while (pos < k) begin
      @(negedge clk);
      pos++;
    end
  endtask

  function automatic logic ovl(input logic [3:0] g);
    return (g[3] & g[2]) | (g[1] & g[0]);
  endfunction

  task automatic load(input logic [8:0] t1, input logic [8:0] t2, input logic [8:0] ph, input logic [1:0] m);
    tau1 = t1; tau2 = t2; phi = ph; modo = m; upd = 1'b1;
    @(negedge clk);
    pos++;
    upd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; upd = 1'b0;
    tau1 = 9'd0; tau2 = 9'd0; phi = 9'd0; modo = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_g1", {4'd0, g1}, 8'h00);
    check("rst_g2", {4'd0, g2}, 8'h00);
    check("rst_sync", {7'd0, sync}, 8'h00);
    check("rst_fault", {7'd0, fault}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // TPS, tau 256 both bridges, phi 0; takes effect at the first wrap
    load(9'd256, 9'd256, 9'd0, 2'b10);
    enable = 1'b1; pos = -1;
    goto(0);    check("en_sync", {7'd0, sync}, 8'h01);
                check("p0_off", {4'd0, g1}, 8'h00);
    goto(1);    check("en_sync_low", {7'd0, sync}, 8'h00);
    goto(1024); check("wrap_sync", {7'd0, sync}, 8'h01);
                check("p1_s0_g1", {4'd0, g1}, 8'h00);
    goto(1027); check("p1_s3_g1", {4'd0, g1}, 8'h00);
    goto(1028); check("p1_s4_g1", {4'd0, g1}, 8'h09);
                check("p1_s4_g2", {4'd0, g2}, 8'h09);
    goto(2048 + 100); check("tps_s100", {4'd0, g1}, 8'h09);
    goto(2048 + 258); check("tps_s258", {4'd0, g1}, 8'h08);
    goto(2048 + 300); check("tps_s300_g1", {4'd0, g1}, 8'h0A);
                      check("tps_s300_g2", {4'd0, g2}, 8'h0A);
    goto(2048 + 514); check("tps_s514", {4'd0, g1}, 8'h02);
    goto(2048 + 600); check("tps_s600", {4'd0, g1}, 8'h06);
    goto(2048 + 800); check("tps_s800", {4'd0, g1}, 8'h05);

    // SPS with phi=+64 loaded mid-period
    goto(2048 + 850); load(9'd0, 9'd0, 9'd64, 2'b01);
    goto(2048 + 1000); check("tps_kept", {4'd0, g1}, 8'h05);
    goto(3072 + 2);   check("sps_s2_g1", {4'd0, g1}, 8'h01);
                      check("sps_s2_g2", {4'd0, g2}, 8'h04);
    goto(3072 + 30);  check("sps_s30_g1", {4'd0, g1}, 8'h09);
                      check("sps_s30_g2", {4'd0, g2}, 8'h06);
    goto(3072 + 66);  check("sps_s66_g2", {4'd0, g2}, 8'h00);
    goto(3072 + 100); check("sps_s100_g2", {4'd0, g2}, 8'h09);

    // phi=-64 loaded at step 300 must not affect this period
    goto(3072 + 299); load(9'd0, 9'd0, 9'h1C0, 2'b01);
    goto(3072 + 560); check("lag_s560_g2", {4'd0, g2}, 8'h09);
    goto(3072 + 578); check("lag_s578_g2", {4'd0, g2}, 8'h00);
    goto(3072 + 600); check("lag_s600_g1", {4'd0, g1}, 8'h06);
                      check("lag_s600_g2", {4'd0, g2}, 8'h06);

    // Full period with phi=-64, scanning every clk for hi/lo overlap
    ov = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      goto(4096 + i);
      ov = ov | ovl(g1) | ovl(g2);
      if (i == 2)   check("lead_s2_g2", {4'd0, g2}, 8'h00);
      if (i == 100) check("lead_s100_g1", {4'd0, g1}, 8'h09);
      if (i == 100) check("lead_s100_g2", {4'd0, g2}, 8'h09);
      if (i == 450) check("lead_s450_g2", {4'd0, g2}, 8'h00);
      if (i == 452) check("lead_s452_g2", {4'd0, g2}, 8'h06);
      if (i == 964) check("lead_s964_g2", {4'd0, g2}, 8'h09);
      if (i == 500) begin
        modo = 2'b11; upd = 1'b1;
      end
      if (i == 501) upd = 1'b0;
    end
    check("no_overlap", {7'd0, ov}, 8'h00);

    // Reserved mode: gates low, no fault
    goto(5120); check("rsv_g1", {4'd0, g1}, 8'h00);
                check("rsv_g2", {4'd0, g2}, 8'h00);
                check("rsv_fault", {7'd0, fault}, 8'h00);
    goto(5120 + 10); load(9'd128, 9'd384, 9'd0, 2'b10);
    goto(5120 + 500); check("rsv_hold", {4'd0, g1}, 8'h00);
    goto(6144 + 2);   check("p6_s2_g1", {4'd0, g1}, 8'h00);
    goto(6144 + 4);   check("p6_s4_g1", {4'd0, g1}, 8'h09);
                      check("p6_s4_g2", {4'd0, g2}, 8'h09);
    goto(6144 + 200); check("p6_s200_g1", {4'd0, g1}, 8'h0A);
                      check("p6_s200_g2", {4'd0, g2}, 8'h09);
    goto(6144 + 600); check("p6_s600_g1", {4'd0, g1}, 8'h06);
                      check("p6_s600_g2", {4'd0, g2}, 8'h06);
    goto(6144 + 650); check("p6_s650_g1", {4'd0, g1}, 8'h05);
                      check("p6_s650_g2", {4'd0, g2}, 8'h06);

    // Disable at step 700, then re-enable from step 0
    goto(6144 + 699); enable = 1'b0;
    goto(6144 + 700); check("dis_g1", {4'd0, g1}, 8'h00);
                      check("dis_g2", {4'd0, g2}, 8'h00);
                      check("dis_sync", {7'd0, sync}, 8'h00);
    goto(6144 + 720); check("dis_hold", {4'd0, g1}, 8'h00);
    enable = 1'b1; pos = -1;
    goto(0);   check("reen_sync", {7'd0, sync}, 8'h01);
               check("reen_g1", {4'd0, g1}, 8'h00);
    goto(1);   check("reen_sync_low", {7'd0, sync}, 8'h00);
    goto(4);   check("reen_s4_g1", {4'd0, g1}, 8'h09);
    goto(200); check("reen_s200_g1", {4'd0, g1}, 8'h0A);

`ifdef DAB_GATE_SHOOTTHRU_EN
    force dut.hi_r = 4'b0001;
    force dut.lo_r = 4'b0001;
    @(negedge clk);
    release dut.hi_r;
    release dut.lo_r;
    repeat (2) @(negedge clk);
    check("st_fault", {7'd0, fault}, 8'h01);
    check("st_g1", {4'd0, g1}, 8'h00);
    check("st_g2", {4'd0, g2}, 8'h00);
    pos = pos + 3;
`else
    check("no_checker_fault", {7'd0, fault}, 8'h00);
`endif

    // Asynchronous reset mid-period
    goto(300);
    rst = 1'b1;
    #1;
    check("arst_g1", {4'd0, g1}, 8'h00);
    check("arst_g2", {4'd0, g2}, 8'h00);
    check("arst_sync", {7'd0, sync}, 8'h00);
    check("arst_fault", {7'd0, fault}, 8'h00);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("post_rst_sync", {7'd0, sync}, 8'h01);
    @(negedge clk);
    check("post_rst_sync_low", {7'd0, sync}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
